// File: rtl/spi_xfer_queue_pkg.sv
// spi_xfer_queue_pkg: shared FSM state encoding and width helper for the SPI blocks
// Contents: ST_* state codes, state_t enum, f_clog2() ceiling log2 for sizing counters/pointers
package spi_xfer_queue_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        GAP   = ST_GAP
    } state_t;
    function automatic int f_clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
endpackage

// File: rtl/spi_xfer_queue_if.sv
// spi_xfer_queue_if: stream and SPI-master handshake bundle for spi_xfer_queue
// slave modport (queue side): in tx_data/tx_valid/rx_ready/m_finish/m_data_out,
//   out tx_ready/rx_data/rx_valid/m_data_in/m_start/busy/tx_level/rx_level
// master modport: the mirror image, for the producer/consumer/master environment
interface spi_xfer_queue_if
    import spi_xfer_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = f_clog2(FIFO_DEPTH) + 1;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] m_data_in;
    logic                  m_start;
    logic                  m_finish;
    logic [DATA_WIDTH-1:0] m_data_out;
    logic                  busy;
    logic [LW-1:0]         tx_level;
    logic [LW-1:0]         rx_level;
    modport slave (
        input  tx_data, tx_valid, rx_ready, m_finish, m_data_out,
        output tx_ready, rx_data, rx_valid, m_data_in, m_start, busy, tx_level, rx_level
    );
    modport master (
        output tx_data, tx_valid, rx_ready, m_finish, m_data_out,
        input  tx_ready, rx_data, rx_valid, m_data_in, m_start, busy, tx_level, rx_level
    );
endinterface

// File: rtl/spi_xfer_queue_sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO with occupancy output
// Ports: clk, rst_n (async active-low); push/din write side, full;
//        pop/dout read side (dout valid while !empty), empty; level = occupancy 0..DEPTH
module sync_fifo
    import spi_xfer_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [f_clog2(DEPTH):0]  level
);
    localparam int AW = f_clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;
    // Ready is purely !full, so a push into a full FIFO is refused even when a pop coincides
    assign full   = r_level == (AW+1)'(DEPTH);
    assign empty  = r_level == '0;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];
    assign level  = r_level;
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end
    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: buffered TX/RX front-end feeding an SPI master one word at a time
// Ports: clk, rst_n (async active-low); bus (spi_xfer_queue_if.slave):
//   tx stream in, rx stream out, m_data_in/m_start to master, m_finish/m_data_out from master,
//   busy and FIFO occupancy status
module spi_xfer_queue
    import spi_xfer_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 4
) (
    input logic             clk,
    input logic             rst_n,
    spi_xfer_queue_if.slave bus
);
    localparam int GW = f_clog2(GAP_CYCLES) + 1;
    state_t                r_state;
    logic                  r_start;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic [GW-1:0]         r_gap;
    logic                  w_tx_empty;
    logic                  w_tx_full;
    logic                  w_rx_empty;
    logic                  w_rx_full;
    logic                  w_issue;
    logic                  w_rx_push;
    logic [DATA_WIDTH-1:0] w_tx_dout;
    // Issuing only with RX room guarantees the capture in WAIT can never be dropped
    assign w_issue   = r_state == IDLE && !w_tx_empty && !w_rx_full;
    assign w_rx_push = r_state == WAIT && bus.m_finish;
    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.tx_valid),
        .din   (bus.tx_data),
        .full  (w_tx_full),
        .pop   (w_issue),
        .dout  (w_tx_dout),
        .empty (w_tx_empty),
        .level (bus.tx_level)
    );
    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_rx_push),
        .din   (bus.m_data_out),
        .full  (w_rx_full),
        .pop   (bus.rx_ready),
        .dout  (bus.rx_data),
        .empty (w_rx_empty),
        .level (bus.rx_level)
    );
    assign bus.tx_ready  = !w_tx_full;
    assign bus.rx_valid  = !w_rx_empty;
    assign bus.m_start   = r_start;
    assign bus.m_data_in = r_data_in;
    assign bus.busy      = r_state != IDLE || !w_tx_empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_start   <= 1'b0;
            r_data_in <= '0;
            r_gap     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state   <= ISSUE;
                        r_start   <= 1'b1;
                        r_data_in <= w_tx_dout;
                    end
                end
                ISSUE: begin
                    r_start <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus.m_finish) begin
                        r_state <= GAP;
                        r_gap   <= GW'(GAP_CYCLES - 1);
                    end
                end
                GAP: begin
                    if (r_gap == '0) r_state <= IDLE;
                    else r_gap <= r_gap - 1'b1;
                end
            endcase
        end
    end
endmodule
